// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: parametrised serial sequence detector.
// A shift register keeps the last N-1 enabled bits and a fill counter tracks
// how many of them are valid. A match is declared when the history is full and
// the history plus the bit on x_in equals PATTERN. Overlap policy, Mealy/Moore
// output style and the width of the saturating match counter are parameters.
module seq_detect_fsm #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   en,
  input  logic                   x_in,
  output logic                   y_out,
  output logic [CNT_W-1:0]       match_count,
  output logic [$clog2(N)-1:0]   fill
);

  localparam int             FW        = $clog2(N);
  localparam logic [FW-1:0]  FILL_LAST = FW'(N - 2);
  localparam logic [FW-1:0]  FILL_ONE  = FW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // FILLING: fewer than N-1 history bits are valid, no match possible yet.
  // ARMED:   history is full, every enabled bit is a match candidate.
  typedef enum logic {
    S_FILLING = 1'b0,
    S_ARMED   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [N-2:0]        hist_q, hist_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                y_q;

  logic [N-2:0]        histShifted;
  logic [N-1:0]        candidate;
  logic                matchHit;

  // The newest bit enters the LSB; with N=2 the history is that single bit.
  generate
    if (N == 2) begin : g_hist_one
      assign histShifted = x_in;
    end else begin : g_hist_many
      assign histShifted = {hist_q[N-3:0], x_in};
    end
  endgenerate

  assign candidate = {hist_q, x_in};

  // A match needs a qualified bit, a full history and an exact pattern hit.
  // Gating with Reset keeps the Mealy output quiet while reset is asserted.
  assign matchHit = en & ~Reset & (state_q == S_ARMED) & (candidate == PATTERN);

  // Next-state logic for the fill FSM, the history and the match counter.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    count_d = count_q;

    if (en) begin
      hist_d = histShifted;
      unique case (state_q)
        S_FILLING: begin
          fill_d = fill_q + FILL_ONE;
          if (fill_q == FILL_LAST) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (matchHit && !OVERLAP) begin
            fill_d  = '0;
            state_d = S_FILLING;
          end
        end
      endcase
    end

    if (matchHit && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // State, history and counter registers; reset discards any partial history.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FILLING;
      fill_q  <= '0;
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  // Moore flag: follows the match of the previous cycle, cleared even when en=0.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= matchHit;
    end
  end

  assign y_out       = MOORE ? y_q : matchHit;
  assign match_count = count_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm: drives six detector configurations from one directed
// bit stream and compares them every cycle against a queue-based model, with
// hand-computed literal expectations pinned to specific cycles.
module tb_seq_detect_fsm;

  localparam int ND = 6;
  // Per instance: pattern length, pattern, overlap, Moore, counter maximum.
  localparam int PN   [ND] = '{3, 3, 3, 3, 3, 2};
  localparam int PPAT [ND] = '{5, 5, 5, 7, 7, 3};
  localparam int POV  [ND] = '{1, 0, 1, 1, 0, 0};
  localparam int PMO  [ND] = '{0, 0, 1, 0, 0, 1};
  localparam int PMAX [ND] = '{255, 255, 255, 3, 3, 255};

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  logic en    = 1'b0;
  logic x_in  = 1'b0;

  logic       y0, y1, y2, y3, y4, y5;
  logic [7:0] c0, c1, c2, c5;
  logic [1:0] c3, c4;
  logic [1:0] f0, f1, f2, f3, f4;
  logic [0:0] f5;

  typedef struct { bit hold; bit pulse; bit e; bit x; } vec_t;
  typedef struct { int vi; int d; int y; int f; int c; } lit_t;

  vec_t vecs[$];
  lit_t lits[$];
  int   vecIdx = -1;
  bit   done   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  bit   mq   [ND][$];
  int   mCnt [ND];
  bit   mPrev[ND];
  int   yS[ND], fS[ND], cS[ND];

  always #5 CLK = ~CLK;

  seq_detect_fsm #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u0 (
    .CLK(CLK), .Reset(Reset), .en(en), .x_in(x_in), .y_out(y0), .match_count(c0), .fill(f0));
  seq_detect_fsm #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u1 (
    .CLK(CLK), .Reset(Reset), .en(en), .x_in(x_in), .y_out(y1), .match_count(c1), .fill(f1));
  seq_detect_fsm #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u2 (
    .CLK(CLK), .Reset(Reset), .en(en), .x_in(x_in), .y_out(y2), .match_count(c2), .fill(f2));
  seq_detect_fsm #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) u3 (
    .CLK(CLK), .Reset(Reset), .en(en), .x_in(x_in), .y_out(y3), .match_count(c3), .fill(f3));
  seq_detect_fsm #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(2)) u4 (
    .CLK(CLK), .Reset(Reset), .en(en), .x_in(x_in), .y_out(y4), .match_count(c4), .fill(f4));
  seq_detect_fsm #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b0), .MOORE(1'b1), .CNT_W(8)) u5 (
    .CLK(CLK), .Reset(Reset), .en(en), .x_in(x_in), .y_out(y5), .match_count(c5), .fill(f5));

  function automatic void addVec(input bit hold, input bit pulse, input bit e, input bit x);
    vec_t v;
    v.hold = hold; v.pulse = pulse; v.e = e; v.x = x;
    vecs.push_back(v);
  endfunction

  // Literal expectation for instance d in the most recently added vector.
  function automatic void addLit(input int d, input int y, input int f, input int c);
    lit_t l;
    l.vi = vecs.size() - 1; l.d = d; l.y = y; l.f = f; l.c = c;
    lits.push_back(l);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d, want %0d", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    Reset = v.hold | v.pulse;
    en    = v.e;
    x_in  = v.x;
    if (v.pulse) begin
      #2;
      Reset = 1'b0;
    end
  endtask

  function automatic void sampleOutputs();
    yS[0] = int'(y0); yS[1] = int'(y1); yS[2] = int'(y2);
    yS[3] = int'(y3); yS[4] = int'(y4); yS[5] = int'(y5);
    fS[0] = int'(f0); fS[1] = int'(f1); fS[2] = int'(f2);
    fS[3] = int'(f3); fS[4] = int'(f4); fS[5] = int'(f5);
    cS[0] = int'(c0); cS[1] = int'(c1); cS[2] = int'(c2);
    cS[3] = int'(c3); cS[4] = int'(c4); cS[5] = int'(c5);
  endfunction

  function automatic void clearModels();
    for (int i = 0; i < ND; i++) begin
      mq[i].delete();
      mCnt[i]  = 0;
      mPrev[i] = 1'b0;
    end
  endfunction

  // The received bits, oldest first, followed by x must spell the pattern
  // from its MSB down to its LSB, and at least N-1 bits must be on record.
  function automatic bit modelMatch(input int i, input bit e, input bit x);
    int p;
    p = PPAT[i];
    if (!e) return 1'b0;
    if (mq[i].size() != PN[i] - 1) return 1'b0;
    for (int j = 0; j < PN[i] - 1; j++) begin
      if (mq[i][j] != p[PN[i] - 1 - j]) return 1'b0;
    end
    return (x == p[0]);
  endfunction

  function automatic void advanceModels(input bit e, input bit x);
    bit m;
    for (int i = 0; i < ND; i++) begin
      m = modelMatch(i, e, x);
      mPrev[i] = m;
      if (e) begin
        mq[i].push_back(x);
        if (mq[i].size() > PN[i] - 1) void'(mq[i].pop_front());
        if (m && (POV[i] == 0)) mq[i].delete();
      end
      if (m && (mCnt[i] < PMAX[i])) mCnt[i]++;
    end
  endfunction

  // Stimulus: build the directed table, then drive one vector per falling edge.
  initial begin
    // 101 stream: overlap, non-overlap and Moore behaviour
    addVec(0,0,1,1); addLit(0,0,0,0);
    addVec(0,0,1,0); addLit(0,0,1,0);
    addVec(0,0,1,1); addLit(0,1,2,0); addLit(1,1,2,0); addLit(2,0,2,0); addLit(5,0,1,0);
    addVec(0,0,1,0); addLit(0,0,2,1); addLit(1,0,0,1); addLit(2,1,2,1);
    addVec(0,0,1,1); addLit(0,1,2,1); addLit(1,0,1,1); addLit(2,0,2,1);
    addVec(0,0,1,0); addLit(0,0,2,2); addLit(1,0,2,1); addLit(2,1,2,2);
    addVec(0,0,1,1); addLit(0,1,2,2); addLit(1,1,2,1); addLit(2,0,2,2);
    addVec(0,0,0,0); addLit(0,0,2,3); addLit(1,0,0,2); addLit(2,1,2,3);
    addVec(0,0,0,1); addLit(2,0,2,3);
    // reset held together with en, then a stream with en gaps
    addVec(1,0,1,1); addLit(0,0,0,0); addLit(1,0,0,0); addLit(2,0,0,0);
    addVec(0,0,1,1); addLit(0,0,0,0);
    addVec(0,0,0,0); addLit(0,0,1,0);
    addVec(0,0,1,0); addLit(0,0,1,0);
    addVec(0,0,0,1); addLit(0,0,2,0);
    addVec(0,0,1,1); addLit(0,1,2,0);
    addVec(0,0,0,0); addLit(0,0,2,1); addLit(2,1,2,1);
    // reset pulse between edges in the middle of 1,0,_,1
    addVec(0,0,1,1); addLit(0,0,2,1); addLit(2,0,2,1);
    addVec(0,0,1,0); addLit(0,0,2,1);
    addVec(0,1,0,0); addLit(0,0,0,0);
    addVec(0,0,1,1); addLit(0,0,0,0);
    addVec(0,0,0,0); addLit(0,0,1,0); addLit(2,0,1,0);
    // seven ones: 111 overlap with 2-bit saturation, 111 and 11 non-overlap
    addVec(1,0,0,0); addLit(3,0,0,0);
    addVec(0,0,1,1); addLit(3,0,0,0); addLit(4,0,0,0);
    addVec(0,0,1,1); addLit(5,0,1,0);
    addVec(0,0,1,1); addLit(3,1,2,0); addLit(4,1,2,0); addLit(5,1,0,1);
    addVec(0,0,1,1); addLit(3,1,2,1); addLit(4,0,0,1);
    addVec(0,0,1,1); addLit(3,1,2,2);
    addVec(0,0,1,1); addLit(3,1,2,3); addLit(4,1,2,1);
    addVec(0,0,1,1); addLit(3,1,2,3); addLit(4,0,0,2);
    addVec(0,0,0,0); addLit(3,0,2,3); addLit(4,0,1,2); addLit(5,0,1,3);
    // mixed tail with sparse enables and occasional reset pulses
    for (int i = 0; i < 80; i++) begin
      addVec(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 1) == 1));
    end

    repeat (2) @(negedge CLK);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      vecIdx = i;
      applyStimulus(vecs[i]);
    end
    @(negedge CLK);
    vecIdx = -1;
    Reset  = 1'b0;
    en     = 1'b0;
    x_in   = 1'b0;
    @(negedge CLK);
    done = 1'b1;
  end

  // Compare: check every cycle before the rising edge, then advance the model.
  initial begin
    bit rstSeen;
    int expY;
    forever begin
      @(negedge CLK);
      #1;
      if (done) break;
      cycle++;
      rstSeen = Reset;
      if (Reset) begin
        sampleOutputs();
        for (int i = 0; i < ND; i++) checkOutput($sformatf("u%0d.y_in_reset", i), yS[i], 0);
      end
      #3;
      if (Reset) rstSeen = 1'b1;
      if (rstSeen) clearModels();
      sampleOutputs();
      for (int i = 0; i < ND; i++) begin
        if (Reset) expY = 0;
        else if (PMO[i] != 0) expY = int'(mPrev[i]);
        else expY = int'(modelMatch(i, en, x_in));
        checkOutput($sformatf("u%0d.y_out", i), yS[i], expY);
        checkOutput($sformatf("u%0d.fill", i), fS[i], mq[i].size());
        checkOutput($sformatf("u%0d.match_count", i), cS[i], mCnt[i]);
      end
      if (vecIdx >= 0) begin
        foreach (lits[k]) begin
          if (lits[k].vi == vecIdx) begin
            checkOutput($sformatf("lit.u%0d.y_out", lits[k].d), yS[lits[k].d], lits[k].y);
            checkOutput($sformatf("lit.u%0d.fill", lits[k].d), fS[lits[k].d], lits[k].f);
            checkOutput($sformatf("lit.u%0d.match_count", lits[k].d), cS[lits[k].d], lits[k].c);
          end
        end
      end
      @(posedge CLK);
      if (Reset) clearModels();
      else advanceModels(en, x_in);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is a fixed-length table, so this only fires on a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
